vx_qos_matrix_arbiter: RTL

- Next-generation matrix (least-recently-granted) arbiter.
- Adds per-requester priority classes, strict priority across classes, matrix LRU fairness within a class, and a valid/ready grant handshake with grant lock.
- Sits in front of shared resources (cache bank ports, memory request muxes, issue slots) where different traffic types need different urgency and where the grant must stay stable until the consumer accepts it.

---
 rtl/vx_arb_pkg.sv | 53 +++++
 rtl/vx_matrix_lru_state.sv | 54 +++++
 rtl/vx_qos_matrix_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vx_arb_pkg.sv
// Shared helpers for the QoS matrix arbiter: width formulas, pair indexing, one-hot encoding.
package vx_arb_pkg;

  // Largest requester count the one-hot encoder covers.
  localparam int unsigned MAX_REQS = 32;

  // Grant-handshake lock states.
  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // Ceil-log2 with a floor of one bit so degenerate sizes still get a field.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the encoded grant index.
  function automatic int unsigned calc_log_reqs(input int unsigned num_reqs);
    return min1_clog2(num_reqs);
  endfunction

  // Width of one priority-class field.
  function automatic int unsigned calc_prio_w(input int unsigned num_prios);
    return min1_clog2(num_prios);
  endfunction

  // Width of a saturating age counter that must hold AGE_MAX.
  function automatic int unsigned calc_age_w(input int unsigned age_max);
    return min1_clog2(age_max + 1);
  endfunction

  // Number of stored matrix bits (one per unordered pair).
  function automatic int unsigned num_pairs(input int unsigned num_reqs);
    return (num_reqs * (num_reqs - 1)) / 2;
  endfunction

  // Flat position of pair (i,j), i<j, in the upper-triangle bit vector.
  function automatic int pair_idx(input int i, input int j, input int n);
    return (i * (2 * n - i - 1)) / 2 + (j - i - 1);
  endfunction

  // One-hot to binary; OR-reduction form so a zero vector yields index 0.
  function automatic logic [31:0] onehot_to_index(input logic [31:0] oh);
    logic [31:0] idx;
    idx = '0;
    for (int k = 0; k < 32; k++) begin
      if (oh[k]) idx = idx | 32'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vx_matrix_lru_state.sv
// Pair-matrix LRU state: picks the least-recently-granted eligible requester and
// demotes the winner below everyone else when its grant fires.
module vx_matrix_lru_state
  import vx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] i_eligible,
  input  logic                i_fire,
  input  logic [NUM_REQS-1:0] i_fire_onehot,
  output logic [NUM_REQS-1:0] o_winner_c
);

  localparam int unsigned NUM_PAIRS = num_pairs(NUM_REQS);
  localparam int unsigned PAIR_W    = (NUM_PAIRS == 0) ? 1 : NUM_PAIRS;
  localparam int unsigned PIDX_W    = min1_clog2(PAIR_W);

  // Bit for pair (i,j), i<j: 1 means j currently beats i.
  logic [PAIR_W-1:0] r_pairs;
  logic              w_beaten;

  // Winner is the eligible requester that no other eligible requester beats.
  always_comb begin
    o_winner_c = '0;
    w_beaten   = 1'b0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      w_beaten = 1'b0;
      for (int j = 0; j < int'(NUM_REQS); j++) begin
        if (j != i && i_eligible[j]) begin
          if (j > i) w_beaten = w_beaten | r_pairs[PIDX_W'(pair_idx(i, j, int'(NUM_REQS)))];
          else       w_beaten = w_beaten | ~r_pairs[PIDX_W'(pair_idx(j, i, int'(NUM_REQS)))];
        end
      end
      o_winner_c[i] = i_eligible[i] & ~w_beaten;
    end
  end

  // On fire, every other requester gains priority over the fired one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pairs <= '0;
    end else if (i_fire) begin
      for (int i = 0; i < int'(NUM_REQS); i++) begin
        for (int j = i + 1; j < int'(NUM_REQS); j++) begin
          if (i_fire_onehot[i])      r_pairs[PIDX_W'(pair_idx(i, j, int'(NUM_REQS)))] <= 1'b1;
          else if (i_fire_onehot[j]) r_pairs[PIDX_W'(pair_idx(i, j, int'(NUM_REQS)))] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/vx_qos_matrix_arbiter.sv
// QoS matrix arbiter: strict priority across classes, LRU matrix within the top
// class, valid/ready grant with lock until accepted.
// Optional aging promotion is enabled by defining VX_QOS_ARB_AGING_EN.
module vx_qos_matrix_arbiter
  import vx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQS     = 4,
  parameter int unsigned NUM_PRIOS    = 2,
  parameter int unsigned AGE_MAX      = 15,
  parameter int unsigned PRIO_W       = calc_prio_w(NUM_PRIOS),
  parameter int unsigned LOG_NUM_REQS = calc_log_reqs(NUM_REQS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQS-1:0]          requests,
  input  logic [NUM_REQS*PRIO_W-1:0]   req_prio,
  input  logic                         grant_ready,
  output logic                         grant_valid,
  output logic [NUM_REQS-1:0]          grant_onehot,
  output logic [LOG_NUM_REQS-1:0]      grant_index
);

  // One extra class bit leaves room for the urgent (aged) class above NUM_PRIOS-1.
  localparam int unsigned CLS_W = PRIO_W + 1;

  if (NUM_REQS < 1 || NUM_REQS > MAX_REQS || NUM_PRIOS < 1 || AGE_MAX < 1) begin : g_cfg_check
    $error("vx_qos_matrix_arbiter: unsupported parameter set");
  end

  logic [CLS_W-1:0]    w_cls [NUM_REQS];
  logic [CLS_W-1:0]    w_top;
  logic [NUM_REQS-1:0] w_elig;
  logic [NUM_REQS-1:0] w_win_oh;
  logic [NUM_REQS-1:0] w_grant_oh;
  logic                w_valid;
  logic                w_fire;
  lock_state_e         r_state;
  lock_state_e         w_state_nxt;
  logic [NUM_REQS-1:0] r_lock_oh;
  logic [NUM_REQS-1:0] w_lock_oh_nxt;
  logic [NUM_REQS-1:0] w_urgent;

`ifdef VX_QOS_ARB_AGING_EN
  localparam int unsigned AGE_W = calc_age_w(AGE_MAX);

  logic [AGE_W-1:0] r_age [NUM_REQS];

  // A saturated counter marks the requester urgent until it fires or drops.
  always_comb begin
    w_urgent = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      w_urgent[i] = (r_age[i] == AGE_W'(AGE_MAX));
    end
  end

  // Count waiting cycles per requester; clear on own fire or request drop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REQS); i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQS); i++) begin
        if (!requests[i] || (w_fire && w_grant_oh[i])) r_age[i] <= '0;
        else if (r_age[i] != AGE_W'(AGE_MAX))          r_age[i] <= r_age[i] + AGE_W'(1);
      end
    end
  end
`else
  assign w_urgent = '0;
`endif

  // Effective class per requester, top class among requesters, and the eligible set.
  always_comb begin
    w_top  = '0;
    w_elig = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      w_cls[i] = (NUM_PRIOS > 1) ? CLS_W'(req_prio[i*PRIO_W +: PRIO_W]) : '0;
      if (w_urgent[i]) w_cls[i] = CLS_W'(NUM_PRIOS);
      if (requests[i] && (w_cls[i] > w_top)) w_top = w_cls[i];
    end
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      w_elig[i] = requests[i] && (w_cls[i] == w_top);
    end
  end

  if (NUM_REQS > 1) begin : g_matrix
    vx_matrix_lru_state #(
      .NUM_REQS (NUM_REQS)
    ) u_lru (
      .clk           (clk),
      .reset         (reset),
      .i_eligible    (w_elig),
      .i_fire        (w_fire),
      .i_fire_onehot (w_grant_oh),
      .o_winner_c    (w_win_oh)
    );
  end else begin : g_single
    assign w_win_oh = w_elig;
  end

  // Lock state register and captured grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= LOCK_IDLE;
      r_lock_oh <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_oh <= w_lock_oh_nxt;
    end
  end

  // Present the live winner when idle, the captured grant while held.
  always_comb begin
    w_state_nxt   = r_state;
    w_lock_oh_nxt = r_lock_oh;
    w_grant_oh    = w_win_oh;
    w_valid       = |w_elig;
    case (r_state)
      LOCK_IDLE: begin
        if (w_valid && !grant_ready) begin
          w_state_nxt   = LOCK_HELD;
          w_lock_oh_nxt = w_win_oh;
        end
      end
      LOCK_HELD: begin
        w_grant_oh = r_lock_oh;
        w_valid    = 1'b1;
        if (grant_ready) begin
          w_state_nxt   = LOCK_IDLE;
          w_lock_oh_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = LOCK_IDLE;
        w_lock_oh_nxt = '0;
      end
    endcase
  end

  assign w_fire       = w_valid & grant_ready;
  assign grant_valid  = w_valid;
  assign grant_onehot = w_grant_oh;
  assign grant_index  = LOG_NUM_REQS'(onehot_to_index(32'(w_grant_oh)));

endmodule
